// File: rtl/stopwatch_bcd_display_if.sv
// Bus between the stopwatch counter (master) and the BCD/7-segment display block (slave).
// Carries the load/busy request, the converted result and the display pins.
interface stopwatch_bcd_display_if #(
  parameter int DATA_WIDTH = 16,
  parameter int DIGITS     = 4
);
  logic [DATA_WIDTH-1:0] count;
  logic                  load;
  logic                  busy;
  logic [4*DIGITS-1:0]   bcd;
  logic                  bcd_valid;
  logic                  overflow;
  logic [6:0]            seg;
  logic [DIGITS-1:0]     an;

  modport master (output count, load,
                  input  busy, bcd, bcd_valid, overflow, seg, an);
  modport slave  (input  count, load,
                  output busy, bcd, bcd_valid, overflow, seg, an);
endinterface

// File: rtl/stopwatch_bcd_display.sv
// Binary-to-BCD (double-dabble) converter with a scanned 7-segment display of the last full result.
// Optional LEADING_ZERO_BLANK_EN: blank leading zero digits (digit 0 always shown).
module stopwatch_bcd_display #(
  parameter int DATA_WIDTH = 16,
  parameter int DIGITS     = 4,
  parameter int SCAN_DIV   = 4
) (
  input  logic clk,
  input  logic reset,
  stopwatch_bcd_display_if.slave bus
);
  localparam int SW = 4*DIGITS + 4;
  localparam int CW = $clog2(DATA_WIDTH + 1);
  localparam int PW = $clog2(SCAN_DIV + 1);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [63:0] LIMIT = 64'(10**DIGITS);

  typedef enum logic [1:0] {IDLE, CONVERT, DONE} state_t;

  state_t                state, state_nxt;
  logic [DATA_WIDTH-1:0] sh;
  logic [SW-1:0]         scr, scr_adj;
  logic [CW-1:0]         it;
  logic                  ovf_pend;
  logic [4*DIGITS-1:0]   bcd_r;
  logic                  ovf_r, valid_r;
  logic [PW-1:0]         pre;
  logic [IW-1:0]         idx;
  logic [DIGITS-1:0]     an_r;
  logic [6:0]            seg_r;
  logic [3:0]            cur_digit;
  logic                  blank;

  function automatic logic [6:0] dec7(input logic [3:0] d);
    case (d)
      4'd0: dec7 = 7'h3F;
      4'd1: dec7 = 7'h06;
      4'd2: dec7 = 7'h5B;
      4'd3: dec7 = 7'h4F;
      4'd4: dec7 = 7'h66;
      4'd5: dec7 = 7'h6D;
      4'd6: dec7 = 7'h7D;
      4'd7: dec7 = 7'h07;
      4'd8: dec7 = 7'h7F;
      4'd9: dec7 = 7'h6F;
      default: dec7 = 7'h00;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.load) state_nxt = CONVERT;
      CONVERT: if (it == CW'(DATA_WIDTH - 1)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Add-3 correction on every scratch digit before the shift.
  always_comb begin
    scr_adj = scr;
    for (int d = 0; d <= DIGITS; d++)
      if (scr[4*d +: 4] >= 4'd5) scr_adj[4*d +: 4] = scr[4*d +: 4] + 4'd3;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sh       <= '0;
      scr      <= '0;
      it       <= '0;
      ovf_pend <= 1'b0;
      bcd_r    <= '0;
      ovf_r    <= 1'b0;
      valid_r  <= 1'b0;
    end else begin
      valid_r <= 1'b0;
      case (state)
        IDLE: if (bus.load) begin
          sh       <= bus.count;
          scr      <= '0;
          it       <= '0;
          ovf_pend <= (64'(bus.count) >= LIMIT);
        end
        CONVERT: begin
          scr <= SW'({scr_adj, sh[DATA_WIDTH-1]});
          sh  <= sh << 1;
          it  <= it + 1'b1;
        end
        DONE: begin
          bcd_r   <= ovf_pend ? {DIGITS{4'h9}} : scr[4*DIGITS-1:0];
          ovf_r   <= ovf_pend;
          valid_r <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign cur_digit = bcd_r[4*idx +: 4];

`ifdef LEADING_ZERO_BLANK_EN
  logic [DIGITS-1:0] zhi;
  // zhi[i]: digit i and every digit above it are zero.
  always_comb begin
    logic run;
    run = 1'b1;
    zhi = '0;
    for (int i = DIGITS-1; i >= 0; i--) begin
      run    = run & (bcd_r[4*i +: 4] == 4'd0);
      zhi[i] = run;
    end
  end
  assign blank = zhi[idx] && (idx != '0);
`else
  assign blank = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      pre   <= '0;
      idx   <= '0;
      an_r  <= DIGITS'(1);
      seg_r <= 7'h3F;
    end else begin
      if (pre == PW'(SCAN_DIV - 1)) begin
        pre <= '0;
        idx <= (idx == IW'(DIGITS - 1)) ? '0 : idx + 1'b1;
      end else begin
        pre <= pre + 1'b1;
      end
      an_r  <= DIGITS'(1) << idx;
      seg_r <= blank ? 7'h00 : dec7(cur_digit);
    end
  end

  assign bus.busy      = (state != IDLE);
  assign bus.bcd       = bcd_r;
  assign bus.bcd_valid = valid_r;
  assign bus.overflow  = ovf_r;
  assign bus.seg       = seg_r;
  assign bus.an        = an_r;
endmodule
